// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute unit: opcodes, FSM states and default width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ADD_OP = 4'd0;
    localparam logic [3:0] SUB_OP = 4'd1;
    localparam logic [3:0] AND_OP = 4'd2;
    localparam logic [3:0] OR_OP  = 4'd3;
    localparam logic [3:0] XOR_OP = 4'd4;
    localparam logic [3:0] NOT_OP = 4'd5;
    localparam logic [3:0] SLA_OP = 4'd6;
    localparam logic [3:0] SRA_OP = 4'd7;
    localparam logic [3:0] SRL_OP = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } aluState_t;

    function automatic logic isShiftOp(input logic [3:0] op);
        return (op == SLA_OP) || (op == SRA_OP) || (op == SRL_OP);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-bit shifter used by the iterative shift datapath.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [3:0]       i_mode,
    output logic [WIDTH-1:0] o_shifted,
    output logic             o_bitOut
);

    // Non-shift modes pass the value through untouched with no bit out.
    always_comb begin
        o_shifted = i_value;
        o_bitOut  = 1'b0;
        case (i_mode)
            SLA_OP: begin
                o_shifted = {i_value[WIDTH-2:0], 1'b0};
                o_bitOut  = i_value[WIDTH-1];
            end
            SRA_OP: begin
                o_shifted = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
                o_bitOut  = i_value[0];
            end
            SRL_OP: begin
                o_shifted = {1'b0, i_value[WIDTH-1:1]};
                o_bitOut  = i_value[0];
            end
            default: begin
                o_shifted = i_value;
                o_bitOut  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic, iterative one-bit-per-cycle shifts,
// valid/ready handshakes on both the request and result sides.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               inValid,
    output logic               inReady,
    input  logic [WIDTH-1:0]   operandA,
    input  logic [WIDTH-1:0]   operandB,
    input  logic [3:0]         aluOp,
    input  logic [SHAMT_W-1:0] shiftAmount,
    output logic               outValid,
    input  logic               outReady,
    output logic [WIDTH-1:0]   res,
    output logic               zeroFlag,
    output logic               carryFlag,
    output logic               busy
);

    aluState_t          r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_mode;
    logic [WIDTH-1:0]   r_res;
    logic               r_zero;
    logic               r_carry;
    logic               r_outValid;

    logic [WIDTH-1:0]   w_aluRes;
    logic               w_aluCarry;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_bitOut;
    logic               w_shiftStart;

    assign inReady   = (r_state == IDLE) & enable & ~rst;
    assign busy      = (r_state != IDLE);
    assign outValid  = r_outValid;
    assign res       = r_res;
    assign zeroFlag  = r_zero;
    assign carryFlag = r_carry;

    assign w_shiftStart = isShiftOp(aluOp) && (shiftAmount != '0);

    // One-cycle results; a zero-distance shift returns operandA with no carry.
    always_comb begin
        w_aluRes   = '0;
        w_aluCarry = 1'b0;
        case (aluOp)
            ADD_OP:                 {w_aluCarry, w_aluRes} = {1'b0, operandA} + {1'b0, operandB};
            SUB_OP: begin
                w_aluRes   = operandA - operandB;
                w_aluCarry = (operandA < operandB);
            end
            AND_OP:                 w_aluRes = operandA & operandB;
            OR_OP:                  w_aluRes = operandA | operandB;
            XOR_OP:                 w_aluRes = operandA ^ operandB;
            NOT_OP:                 w_aluRes = ~operandA;
            SLA_OP, SRA_OP, SRL_OP: w_aluRes = operandA;
            default: begin
                w_aluRes   = '0;
                w_aluCarry = 1'b0;
            end
        endcase
    end

    alu_shift_step #(
        .WIDTH(WIDTH)
    ) u_shiftStep (
        .i_value  (r_work),
        .i_mode   (r_mode),
        .o_shifted(w_shifted),
        .o_bitOut (w_bitOut)
    );

    // Carry of a shift is simply the bit dropped on the final step, so no running copy is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_cnt      <= '0;
            r_mode     <= ADD_OP;
            r_res      <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_outValid <= 1'b0;
        end else if (enable) begin
            case (r_state)
                IDLE: begin
                    if (inValid) begin
                        if (w_shiftStart) begin
                            r_work  <= operandA;
                            r_cnt   <= shiftAmount;
                            r_mode  <= aluOp;
                            r_state <= SHIFT;
                        end else begin
                            r_res      <= w_aluRes;
                            r_zero     <= (w_aluRes == '0);
                            r_carry    <= w_aluCarry;
                            r_outValid <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_res      <= w_shifted;
                        r_zero     <= (w_shifted == '0);
                        r_carry    <= w_bitOut;
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table plus scoreboard, with
// hand-written sequences for backpressure, enable stalls and reset corner cases.
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] expRes;
        logic        expZero;
        logic        expCarry;
        int          expLat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        inValid;
    logic        inReady;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [3:0]  aluOp;
    logic [4:0]  shiftAmount;
    logic        outValid;
    logic        outReady;
    logic [31:0] res;
    logic        zeroFlag;
    logic        carryFlag;
    logic        busy;

    int   checks   = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_exec_unit #(
        .WIDTH  (32),
        .SHAMT_W(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .inValid    (inValid),
        .inReady    (inReady),
        .operandA   (operandA),
        .operandB   (operandB),
        .aluOp      (aluOp),
        .shiftAmount(shiftAmount),
        .outValid   (outValid),
        .outReady   (outReady),
        .res        (res),
        .zeroFlag   (zeroFlag),
        .carryFlag  (carryFlag),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the scoreboard entry, compares the result, optionally stalls the consumer, then acks.
    task automatic checkOutput(input int lat, input int holdCycles);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard: output with no expected entry");
            return;
        end
        e = sb.pop_front();
        check({e.name, " outValid"}, 32'(outValid), 32'd1);
        if (!outValid) return;
        check({e.name, " res"}, res, e.expRes);
        check({e.name, " zeroFlag"}, 32'(zeroFlag), 32'(e.expZero));
        check({e.name, " carryFlag"}, 32'(carryFlag), 32'(e.expCarry));
        check({e.name, " latency"}, 32'(lat), 32'(e.expLat));
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            check({e.name, " held res"}, res, e.expRes);
            check({e.name, " held outValid"}, 32'(outValid), 32'd1);
            check({e.name, " held inReady"}, 32'(inReady), 32'd0);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check({e.name, " outValid after ack"}, 32'(outValid), 32'd0);
        check({e.name, " inReady after ack"}, 32'(inReady), 32'd1);
    endtask

    // Drives one request; dropAt>0 pulls enable low for 3 edges starting at that latency count.
    task automatic applyStimulus(input vec_t v, input int holdCycles, input int dropAt);
        int lat;
        int guard;
        guard = 0;
        while (!inReady && guard < 50) begin
            tick();
            guard++;
        end
        check({v.name, " inReady before accept"}, 32'(inReady), 32'd1);
        operandA    = v.a;
        operandB    = v.b;
        aluOp       = v.op;
        shiftAmount = v.shamt;
        inValid     = 1'b1;
        tick();
        inValid = 1'b0;
        sb.push_back(v);
        lat = 1;
        while (!outValid && lat < 200) begin
            if (dropAt > 0 && lat == dropAt) enable = 1'b0;
            if (dropAt > 0 && lat == dropAt + 3) enable = 1'b1;
            tick();
            lat++;
        end
        enable = 1'b1;
        checkOutput(lat, holdCycles);
    endtask

    initial begin
        vec_t v;
        rst         = 1'b1;
        enable      = 1'b1;
        inValid     = 1'b0;
        outReady    = 1'b0;
        operandA    = '0;
        operandB    = '0;
        aluOp       = ADD_OP;
        shiftAmount = '0;

        vecs.push_back('{"ADD 30+10",   ADD_OP, 32'd30,         32'd10, 5'd0,  32'd40,         1'b0, 1'b0, 1});
        vecs.push_back('{"ADD wrap",    ADD_OP, 32'hFFFFFFFF,   32'd1,  5'd0,  32'd0,          1'b1, 1'b1, 1});
        vecs.push_back('{"SUB borrow",  SUB_OP, 32'd10,         32'd30, 5'd0,  32'hFFFFFFEC,   1'b0, 1'b1, 1});
        vecs.push_back('{"SUB equal",   SUB_OP, 32'd5,          32'd5,  5'd0,  32'd0,          1'b1, 1'b0, 1});
        vecs.push_back('{"AND",         AND_OP, 32'd14,         32'd3,  5'd0,  32'd2,          1'b0, 1'b0, 1});
        vecs.push_back('{"OR",          OR_OP,  32'd14,         32'd3,  5'd0,  32'd15,         1'b0, 1'b0, 1});
        vecs.push_back('{"XOR",         XOR_OP, 32'd14,         32'd3,  5'd0,  32'd13,         1'b0, 1'b0, 1});
        vecs.push_back('{"NOT",         NOT_OP, 32'hFFFFFFF0,   32'd0,  5'd0,  32'h0000000F,   1'b0, 1'b0, 1});
        vecs.push_back('{"SLA 7<<1",    SLA_OP, 32'd7,          32'd0,  5'd1,  32'd14,         1'b0, 1'b0, 2});
        vecs.push_back('{"SLA msb out", SLA_OP, 32'h80000001,   32'd0,  5'd1,  32'd2,          1'b0, 1'b1, 2});
        vecs.push_back('{"SRA -2>>>1",  SRA_OP, 32'hFFFFFFFE,   32'd0,  5'd1,  32'hFFFFFFFF,   1'b0, 1'b0, 2});
        vecs.push_back('{"SRA sign4",   SRA_OP, 32'h80000000,   32'd0,  5'd4,  32'hF8000000,   1'b0, 1'b0, 5});
        vecs.push_back('{"SRL 14>>3",   SRL_OP, 32'd14,         32'd0,  5'd3,  32'd1,          1'b0, 1'b1, 4});
        vecs.push_back('{"SRL N=31",    SRL_OP, 32'h80000000,   32'd0,  5'd31, 32'd1,          1'b0, 1'b0, 32});
        vecs.push_back('{"SLA N=0",     SLA_OP, 32'd5,          32'd0,  5'd0,  32'd5,          1'b0, 1'b0, 1});
        vecs.push_back('{"illegal 12",  4'd12,  32'd5,          32'd9,  5'd0,  32'd0,          1'b1, 1'b0, 1});

        tick();
        tick();
        check("inReady in reset", 32'(inReady), 32'd0);
        check("reset outValid", 32'(outValid), 32'd0);
        check("reset res", res, 32'd0);
        check("reset zeroFlag", 32'(zeroFlag), 32'd0);
        check("reset carryFlag", 32'(carryFlag), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("inReady after release", 32'(inReady), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle outValid", 32'(outValid), 32'd0);
        end
        enable = 1'b0;
        #1;
        check("inReady with enable low", 32'(inReady), 32'd0);
        enable = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i], 0, 0);

        v = '{"ADD backpressure", ADD_OP, 32'd30, 32'd10, 5'd0, 32'd40, 1'b0, 1'b0, 1};
        applyStimulus(v, 5, 0);

        v = '{"SRL enable stall", SRL_OP, 32'h12345680, 32'd0, 5'd8, 32'h00123456, 1'b0, 1'b1, 12};
        applyStimulus(v, 0, 3);

        // Reset in the middle of a 20-bit shift discards the operation.
        operandA    = 32'd1;
        operandB    = 32'd0;
        aluOp       = SLA_OP;
        shiftAmount = 5'd20;
        inValid     = 1'b1;
        tick();
        inValid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("busy mid-shift", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rst mid-shift outValid", 32'(outValid), 32'd0);
        check("rst mid-shift res", res, 32'd0);
        check("rst mid-shift busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("no late result after rst", 32'(outValid), 32'd0);

        // Reset wins over a simultaneous accept.
        rst         = 1'b1;
        operandA    = 32'd1;
        operandB    = 32'd1;
        aluOp       = ADD_OP;
        shiftAmount = '0;
        inValid     = 1'b1;
        tick();
        rst     = 1'b0;
        inValid = 1'b0;
        check("rst+accept busy", 32'(busy), 32'd0);
        check("rst+accept outValid", 32'(outValid), 32'd0);
        tick();
        check("rst+accept nothing captured", 32'(outValid), 32'd0);

        v = '{"XOR after reset", XOR_OP, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd0, 32'hAAAAAAAA, 1'b0, 1'b0, 1};
        applyStimulus(v, 0, 0);

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execute-stage responder for the ALU operation interface: it accepts one operation request (operands, opcode, shift amount) via a valid/ready handshake and returns a registered result with zero and carry flags via a second valid/ready handshake. Arithmetic and logic ops complete in one cycle. Shifts run iteratively, one bit position per cycle. It sits between the instruction-issue logic and writeback, and is the sink that ALU request streams (including bench stimulus drivers) talk to.

## Interface
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  clock enable. While 0, no state, register or handshake change occurs, and inReady is forced to 0.
- inValid  in  1  request valid.
- inReady  out  1  request ready; equals (state==IDLE) & enable & ~rst.
- operandA  in  WIDTH  first operand; also the shift source.
- operandB  in  WIDTH  second operand.
- aluOp  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SLA, 7 SRA, 8 SRL; 9–15 illegal.
- shiftAmount  in  SHAMT_W  shift distance for ops 6–8; ignored otherwise.
- outValid  out  1  result valid.
- outReady  in  1  result consumer ready.
- res  out  WIDTH  result.
- zeroFlag  out  1  res == 0.
- carryFlag  out  1  carry/borrow/last-bit-out.
- busy  out  1  state != IDLE.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- **IDLE.** An accept happens on an edge where inValid & inReady. At the accept, all inputs are captured.
  - Op is not a shift, or shift with shiftAmount==0: compute the result and go to DONE.
  - Op is a shift with shiftAmount==N>0: load work=operandA, cnt=N, carry=0, then go to SHIFT.
- **SHIFT.** Each enabled cycle:
  - shift work by 1 bit;
  - carry = the bit shifted out;
  - cnt -= 1.
  - On the edge where cnt goes 1→0, load res/flags from the shifted value and go to DONE.
- **DONE.** outValid=1; res and flags are held stable. On outValid & outReady, go to IDLE. No new accept happens in that same cycle.
- **Arithmetic rules** (all modulo 2^WIDTH):
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: res = A−B; carry = borrow, i.e. 1 iff A<B unsigned.
  - AND, OR, XOR: carry = 0.
  - NOT: res = ~operandA; carry = 0.
- **Shift rules:**
  - SLA: left shift, zero fill.
  - SRA: right shift, sign fill.
  - SRL: right shift, zero fill.
  - Shift carry = last bit shifted out; 0 when N=0.
- **Illegal opcode:** res=0, zeroFlag=1, carryFlag=0; handled as a one-cycle op.
- zeroFlag is always computed from the final res.

## Timing
- **Reset values:** state=IDLE, outValid=0, res=0, zeroFlag=0, carryFlag=0, busy=0. inReady=0 while rst=1 and 1 on the first cycle after release (when enable=1).
- **Latency:** accept at edge E.
  - Non-shift ops and N=0: outValid=1 in the cycle after E.
  - Shift with N>0: outValid=1 N cycles after that.
  - Both latencies count enabled cycles only.
- **Throughput:** at most one op per 2 cycles (the DONE→IDLE handshake is not overlapped).
- **Backpressure:** outReady=0 holds DONE indefinitely; res and flags must not change.
- **enable=0 mid-SHIFT:** cnt and work freeze; the op resumes with no lost or extra shift.
- **rst mid-operation** (SHIFT or DONE): the in-flight op is discarded and the unit returns to reset values on the next edge.
- **Simultaneous rst and an accept:** rst wins; nothing is captured.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams (ADD_OP…SRL_OP);
  - the FSM state enum {IDLE, SHIFT, DONE};
  - the default WIDTH.
- One sub-module, alu_shift_step: combinational single-bit shifter.
  - Inputs: value, mode (SLA/SRA/SRL).
  - Outputs: shifted value, bit out.
  - Instantiated once in the SHIFT datapath.
- All single-cycle arithmetic and logic is inline in alu_exec_unit.

## Test plan
- **Reset and idle:** reset, then hold inValid=0 → outValid=0, res=0, inReady=1 after rst release.
- **ADD with carry:**
  - A=30, B=10, op 0 → res=40, zeroFlag=0, carryFlag=0, outValid one cycle after accept.
  - A=0xFFFFFFFF, B=1 → res=0, zeroFlag=1, carryFlag=1.
- **SUB borrow and logic ops:**
  - SUB A=10, B=30 → res=0xFFFFFFEC, carryFlag=1.
  - AND/OR/XOR with A=14, B=3 → 2 / 15 / 13.
  - NOT A=0xFFFFFFF0 → res=0x0000000F.
- **Shifts:**
  - SLA A=7, N=1 → res=14, latency 2.
  - SRA A=0xFFFFFFFE, N=1 → res=0xFFFFFFFF, carryFlag=0.
  - SRL A=14, N=3 → res=1, carryFlag=1, latency 4.
- **Backpressure and enable:**
  - Hold outReady=0 for 5 cycles in DONE → res stays stable and inReady=0.
  - Drop enable for 3 cycles mid-SRL with N=8 → result is still A>>8, and latency grows by exactly 3.
- **Reset and illegal opcode:**
  - Assert rst during the SHIFT of a 20-bit shift → next cycle outValid=0, res=0, busy=0.
  - Illegal op 12 → res=0, zeroFlag=1.
